// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: game-logic controller for the maze.
// Sequences wall-check reads on maze ROM port B, moves the player one block per
// accepted button pulse, and tracks the 2 s interval timer for win/lose.
// Optional feature macro: MOVE_COUNTER_EN adds o_move_count (successful moves).
module maze_move_ctrl #(
  parameter int unsigned START_BCOL       = 1,
  parameter int unsigned START_BROW       = 1,
  parameter int unsigned EXIT_BCOL        = 38,
  parameter int unsigned EXIT_BROW        = 27,
  parameter int unsigned MAX_BCOL         = 39,
  parameter int unsigned MAX_BROW         = 28,
  parameter logic [11:0] WALL_RGB         = 12'h000,
  parameter int unsigned CLK_PER_INTERVAL = 50_000_000,
  parameter int unsigned MAX_INTERVALS    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_restart,
  output logic        o_rom_en,
  output logic [10:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic [5:0]  o_two_seconds_intervals,
  output logic        o_win,
  output logic        o_lose
`ifdef MOVE_COUNTER_EN
  ,
  output logic [15:0] o_move_count
`endif
);

  localparam int unsigned CycW = (CLK_PER_INTERVAL > 1) ? $clog2(CLK_PER_INTERVAL) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(CLK_PER_INTERVAL - 1);
  localparam logic [5:0] StartCol = 6'(START_BCOL);
  localparam logic [5:0] StartRow = 6'(START_BROW);
  localparam logic [5:0] ExitCol  = 6'(EXIT_BCOL);
  localparam logic [5:0] ExitRow  = 6'(EXIT_BROW);
  localparam logic [5:0] MaxCol   = 6'(MAX_BCOL);
  localparam logic [5:0] MaxRow   = 6'(MAX_BROW);
  localparam logic [5:0] MaxIvl   = 6'(MAX_INTERVALS);

  typedef enum logic [2:0] {StPlay, StRead, StCheck, StWin, StLose} state_e;

  state_e          state_q;
  logic [5:0]      pos_col_q, pos_row_q;
  logic [5:0]      tgt_col_q, tgt_row_q;
  logic [CycW-1:0] cyc_q;
  logic [5:0]      ivl_q;
  logic            win_q, lose_q;
`ifdef MOVE_COUNTER_EN
  logic [15:0]     move_cnt_q;
`endif

  logic       mv_ok;
  logic [5:0] nxt_col, nxt_row;
  logic       tick_wrap;
  logic [5:0] ivl_next;
  logic       timeout;
  logic       hit_wall;
  logic [5:0] land_col, land_row;
  logic       at_exit;
  logic       restart_ok;

  // Target block for the highest-priority pulse; mv_ok only if it stays on the grid.
  always_comb begin
    mv_ok   = 1'b0;
    nxt_col = pos_col_q;
    nxt_row = pos_row_q;
    if (i_up) begin
      mv_ok   = (pos_row_q != 6'd0);
      nxt_row = pos_row_q - 6'd1;
    end else if (i_down) begin
      mv_ok   = (pos_row_q < MaxRow);
      nxt_row = pos_row_q + 6'd1;
    end else if (i_left) begin
      mv_ok   = (pos_col_q != 6'd0);
      nxt_col = pos_col_q - 6'd1;
    end else if (i_right) begin
      mv_ok   = (pos_col_q < MaxCol);
      nxt_col = pos_col_q + 6'd1;
    end
  end

  // Timer next-state and CHECK-stage landing position.
  always_comb begin
    tick_wrap  = (cyc_q == CycLast);
    ivl_next   = (tick_wrap && (ivl_q != MaxIvl)) ? ivl_q + 6'd1 : ivl_q;
    timeout    = (ivl_next == MaxIvl);
    hit_wall   = (i_rom_data[15:4] == WALL_RGB);
    land_col   = hit_wall ? pos_col_q : tgt_col_q;
    land_row   = hit_wall ? pos_row_q : tgt_row_q;
    at_exit    = (land_col == ExitCol) && (land_row == ExitRow);
    restart_ok = i_restart && ((state_q == StWin) || (state_q == StLose));
  end

  // Game FSM with timer, position and status registers.
  always_ff @(posedge clk) begin
    if (rst || restart_ok) begin
      state_q    <= StPlay;
      pos_col_q  <= StartCol;
      pos_row_q  <= StartRow;
      tgt_col_q  <= StartCol;
      tgt_row_q  <= StartRow;
      cyc_q      <= '0;
      ivl_q      <= 6'd0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
`ifdef MOVE_COUNTER_EN
      move_cnt_q <= 16'd0;
`endif
    end else begin
      if ((state_q == StPlay) || (state_q == StRead) || (state_q == StCheck)) begin
        cyc_q <= tick_wrap ? '0 : cyc_q + 1'b1;
        ivl_q <= ivl_next;
      end
      unique case (state_q)
        StPlay: begin
          if (timeout) begin
            state_q <= StLose;
            lose_q  <= 1'b1;
          end else if (mv_ok) begin
            tgt_col_q <= nxt_col;
            tgt_row_q <= nxt_row;
            state_q   <= StRead;
          end
        end
        StRead: begin
          if (timeout) begin
            state_q <= StLose;
            lose_q  <= 1'b1;
          end else begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          pos_col_q <= land_col;
          pos_row_q <= land_row;
`ifdef MOVE_COUNTER_EN
          if (!hit_wall && (move_cnt_q != 16'hFFFF)) move_cnt_q <= move_cnt_q + 16'd1;
`endif
          // Reaching the exit wins even if the timer expires on the same edge.
          if (at_exit) begin
            state_q <= StWin;
            win_q   <= 1'b1;
          end else if (timeout) begin
            state_q <= StLose;
            lose_q  <= 1'b1;
          end else begin
            state_q <= StPlay;
          end
        end
        StWin, StLose: ;
        default: state_q <= StPlay;
      endcase
    end
  end

  // ROM port-B request decoded from state only; row fits 5 bits so the concat is row*64+col.
  always_comb begin
    o_rom_en   = (state_q == StRead);
    o_rom_addr = o_rom_en ? {tgt_row_q[4:0], tgt_col_q} : 11'd0;
  end

  assign o_player_bcol           = pos_col_q;
  assign o_player_brow           = pos_row_q;
  assign o_exit_bcol             = ExitCol;
  assign o_exit_brow             = ExitRow;
  assign o_two_seconds_intervals = ivl_q;
  assign o_win                   = win_q;
  assign o_lose                  = lose_q;
`ifdef MOVE_COUNTER_EN
  assign o_move_count            = move_cnt_q;
`endif

  // Colour-only ROM bits and the target row MSB carry no game meaning.
  logic unused_bits;
  assign unused_bits = ^{i_rom_data[3:0], tgt_row_q[5]};

endmodule
